// File: rtl/bounce_emulator.sv
`default_nettype none
// ============================================================================
// Module   : bounce_emulator
// Purpose  : Turns a clean level request into a contact-bounce waveform.
//            Each level change produces a burst of pseudo-random toggles
//            ending at the new level. The output then holds that level for a
//            fixed settle window, after which a one-cycle settled pulse is
//            emitted. The burst depends only on SEED, so a model can replay it.
// Revision : 1.0 - initial release
// ============================================================================
module bounce_emulator #(
    parameter int          MAX_BOUNCES = 3,
    parameter int          GAP_BITS    = 4,
    parameter int          MIN_GAP     = 2,
    parameter int          HOLD_CYCLES = 1024,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic en,
    input  logic clean_in,
    output logic noisy_out,
    output logic busy,
    output logic settled
);

    // Counter widths. The gap counter must hold MIN_GAP + 2^GAP_BITS - 1
    // without wrapping.
    localparam int c_GAP_W = $clog2(MIN_GAP + (1 << GAP_BITS));
    localparam int c_TGL_W = (MAX_BOUNCES > 0) ? $clog2(2 * MAX_BOUNCES + 1) : 1;
    localparam int c_HLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [c_TGL_W-1:0] c_TOGGLES   = c_TGL_W'(2 * MAX_BOUNCES);
    localparam logic [c_HLD_W-1:0] c_HOLD_LOAD = c_HLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_MIN_GAP   = c_GAP_W'(MIN_GAP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t               r_state;
    logic [15:0]          r_lfsr;
    logic                 r_target;
    logic                 r_noisy;
    logic                 r_busy;
    logic                 r_settled;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [c_TGL_W-1:0]   r_toggles_left;
    logic [c_HLD_W-1:0]   r_hold_cnt;

    logic [15:0]          w_lfsr_next;
    logic [c_GAP_W-1:0]   w_gap;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1 shifting right; gap uses the
    // current (pre-advance) value.
    always_comb begin
        w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        w_gap       = c_MIN_GAP + c_GAP_W'(r_lfsr[GAP_BITS-1:0]);
    end

    // Burst sequencer: IDLE waits for a level change, BOUNCE spaces toggles
    // by gap+1 cycles, HOLD times the settle window. Everything freezes
    // while en is low; settled is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_lfsr         <= SEED;
            r_target       <= 1'b0;
            r_noisy        <= 1'b0;
            r_busy         <= 1'b0;
            r_settled      <= 1'b0;
            r_gap_cnt      <= '0;
            r_toggles_left <= '0;
            r_hold_cnt     <= '0;
        end else begin
            r_settled <= 1'b0;
            if (en) begin
                r_lfsr <= w_lfsr_next;
                case (r_state)
                    S_IDLE: begin
                        if (clean_in != r_target) begin
                            r_target       <= clean_in;
                            r_noisy        <= clean_in;
                            r_gap_cnt      <= w_gap;
                            r_toggles_left <= c_TOGGLES;
                            r_busy         <= 1'b1;
                            if (MAX_BOUNCES == 0) begin
                                r_state    <= S_HOLD;
                                r_hold_cnt <= c_HOLD_LOAD;
                            end else begin
                                r_state    <= S_BOUNCE;
                            end
                        end
                    end
                    S_BOUNCE: begin
                        if (r_gap_cnt == '0) begin
                            r_noisy        <= ~r_noisy;
                            r_toggles_left <= r_toggles_left - c_TGL_W'(1);
                            r_gap_cnt      <= w_gap;
                            // Even toggle count: the last toggle lands on target.
                            if (r_toggles_left == c_TGL_W'(1)) begin
                                r_state    <= S_HOLD;
                                r_hold_cnt <= c_HOLD_LOAD;
                            end
                        end else begin
                            r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == '0) begin
                            r_settled <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - c_HLD_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign noisy_out = r_noisy;
    assign busy      = r_busy;
    assign settled   = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_bounce_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_emulator
// Purpose  : Self-checking bench for bounce_emulator. An independent LFSR
//            model predicts every noisy_out edge time and the settled pulse;
//            predictions are queued when stimulus is driven and popped when
//            the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_emulator;

    localparam int          MB      = 3;
    localparam int          MIN_GAP = 2;
    localparam int          HOLD    = 1024;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic a_clean, a_noisy, a_busy, a_settled;
    logic b_clean, b_noisy, b_busy, b_settled;

    always #5 clk = ~clk;

    bounce_emulator #(
        .MAX_BOUNCES(MB), .GAP_BITS(4), .MIN_GAP(MIN_GAP),
        .HOLD_CYCLES(HOLD), .SEED(SEED)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .clean_in(a_clean),
        .noisy_out(a_noisy), .busy(a_busy), .settled(a_settled)
    );

    bounce_emulator #(
        .MAX_BOUNCES(0), .GAP_BITS(4), .MIN_GAP(MIN_GAP),
        .HOLD_CYCLES(8), .SEED(SEED)
    ) dut_b (
        .clk(clk), .rst(rst), .en(1'b1), .clean_in(b_clean),
        .noisy_out(b_noisy), .busy(b_busy), .settled(b_settled)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Posedge counter: after edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: value held here is the one the next edge will use.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst)    m_lfsr <= SEED;
        else if (en) m_lfsr <= step(m_lfsr);
    end

    typedef struct {
        int   t;
        logic v;
        bit   first;
    } nev_t;

    nev_t nq[$];
    int   sq[$];
    int   win_lo = 0, win_hi = 0;
    int   last_exp = 0;
    int   trans_cnt = 0;
    int   last_t = 0;
    bit   mon_on = 1'b0;
    logic prev_noisy = 1'b0;
    nev_t ev;
    int   st;

    // Queue the full expected schedule of an event sampled at edge e.
    task automatic predict(input int e, input logic v, input int hold_extra);
        logic [15:0] l;
        int t, g;
        logic cur;
        l = m_lfsr;
        t = e;
        cur = v;
        nq.push_back('{t: t, v: v, first: 1'b1});
        for (int k = 0; k < 2 * MB; k++) begin
            g = MIN_GAP + int'(l[3:0]);
            for (int j = 0; j < g + 1; j++) l = step(l);
            t += g + 1;
            cur = ~cur;
            nq.push_back('{t: t, v: cur, first: 1'b0});
        end
        last_exp = t;
        sq.push_back(t + HOLD + hold_extra);
        win_lo = e;
        win_hi = t + HOLD + hold_extra;
        trans_cnt = 0;
    endtask

    // Monitor for dut_a, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_on) begin
            if (a_noisy !== prev_noisy) begin
                trans_cnt++;
                if (nq.size() == 0) begin
                    chk("noisy_unexpected_edge", 1, 0);
                end else begin
                    ev = nq.pop_front();
                    chk("noisy_edge_time", cyc, ev.t);
                    chk("noisy_edge_value", int'(a_noisy), int'(ev.v));
                    if (!ev.first)
                        chk("interval_in_range", int'((cyc - last_t) >= 3 && (cyc - last_t) <= 18), 1);
                end
                last_t = cyc;
            end
            prev_noisy = a_noisy;
            if (a_settled) begin
                if (sq.size() == 0) begin
                    chk("settled_unexpected", 1, 0);
                end else begin
                    st = sq.pop_front();
                    chk("settled_time", cyc, st);
                end
            end
            chk("busy", int'(a_busy), int'(cyc >= win_lo && cyc < win_hi));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_settled(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (a_settled) return;
        end
        chk("settle_timeout", 0, 1);
    endtask

    typedef struct {
        logic clean;
        logic exp_final;
        int   exp_trans;
        int   hold_extra;
    } vec_t;

    vec_t vecs[2];
    int   eb, b_trans;
    logic b_prev;

    initial begin
        vecs[0] = '{clean: 1'b1, exp_final: 1'b1, exp_trans: 2 * MB + 1, hold_extra: 0};
        vecs[1] = '{clean: 1'b0, exp_final: 1'b0, exp_trans: 2 * MB + 1, hold_extra: 0};

        // Reset, then idle with clean_in low.
        rst = 1'b0; en = 1'b1; a_clean = 1'b0; b_clean = 1'b0;
        repeat (3) tick();
        chk("reset_noisy", int'(a_noisy), 0);
        chk("reset_busy", int'(a_busy), 0);
        chk("reset_settled", int'(a_settled), 0);
        rst = 1'b1;
        prev_noisy = a_noisy;
        mon_on = 1'b1;
        repeat (50) tick();
        chk("idle_noisy", int'(a_noisy), 0);

        // Clean single edge with no bounces and an 8-cycle settle window.
        b_clean = 1'b1;
        eb = cyc + 1;
        b_prev = b_noisy;
        b_trans = 0;
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (b_noisy !== b_prev) b_trans++;
            b_prev = b_noisy;
            chk("b_cycle", cyc, eb + k);
            chk("b_noisy", int'(b_noisy), 1);
            chk("b_busy", int'(b_busy), int'(k < 8));
            chk("b_settled", int'(b_settled), int'(k == 8));
        end
        chk("b_transitions", b_trans, 1);

        // Table-driven rising and falling bursts.
        foreach (vecs[i]) begin
            a_clean = vecs[i].clean;
            predict(cyc + 1, vecs[i].clean, vecs[i].hold_extra);
            wait_settled(HOLD + 400);
            chk("final_level", int'(a_noisy), int'(vecs[i].exp_final));
            chk("transitions", trans_cnt, vecs[i].exp_trans);
            chk("queue_drained", nq.size() + sq.size(), 0);
            repeat (5) tick();
        end

        // Pulse on clean_in inside BOUNCE is ignored; target already 1 after.
        a_clean = 1'b1;
        predict(cyc + 1, 1'b1, 0);
        repeat (5) tick();
        a_clean = 1'b0;
        repeat (2) tick();
        a_clean = 1'b1;
        wait_settled(HOLD + 400);
        chk("ignored_transitions", trans_cnt, 2 * MB + 1);
        repeat (30) tick();
        chk("no_new_event_busy", int'(a_busy), 0);
        chk("no_new_event_noisy", int'(a_noisy), 1);

        // A mismatch left during BOUNCE starts a new burst right after settled.
        a_clean = 1'b0;
        predict(cyc + 1, 1'b0, 0);
        repeat (5) tick();
        a_clean = 1'b1;
        wait_settled(HOLD + 400);
        chk("pending_first_transitions", trans_cnt, 2 * MB + 1);
        predict(cyc + 1, 1'b1, 0);
        wait_settled(HOLD + 400);
        chk("pending_second_transitions", trans_cnt, 2 * MB + 1);
        chk("pending_final_level", int'(a_noisy), 1);

        // en low for 20 cycles during HOLD delays settled by 20 cycles.
        a_clean = 1'b0;
        predict(cyc + 1, 1'b0, 20);
        for (int i = 0; i < 400 && cyc < last_exp + 5; i++) tick();
        en = 1'b0;
        repeat (20) tick();
        en = 1'b1;
        wait_settled(HOLD + 400);
        chk("en_gap_transitions", trans_cnt, 2 * MB + 1);
        chk("en_gap_drained", nq.size() + sq.size(), 0);
        repeat (5) tick();

        // Reset mid-burst aborts asynchronously and reloads SEED.
        a_clean = 1'b1;
        predict(cyc + 1, 1'b1, 0);
        repeat (6) tick();
        mon_on = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("abort_noisy", int'(a_noisy), 0);
        chk("abort_busy", int'(a_busy), 0);
        chk("abort_settled", int'(a_settled), 0);
        nq.delete();
        sq.delete();
        win_lo = 0;
        win_hi = 0;
        repeat (2) tick();
        rst = 1'b1;
        prev_noisy = a_noisy;
        mon_on = 1'b1;
        // clean_in is still 1 against target 0, so the next edge starts a
        // burst whose schedule comes from SEED.
        predict(cyc + 1, 1'b1, 0);
        wait_settled(HOLD + 400);
        chk("post_reset_transitions", trans_cnt, 2 * MB + 1);
        chk("post_reset_drained", nq.size() + sq.size(), 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
